melody_player: RTL and testbench
================================

MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 Parameters: DIV_US, default 50, meaning clk cycles per 1 us tick (DIV_US >= 1).
REQ-002 Parameters: HP_W, default 12, meaning note half-period width in us.
REQ-003 Parameters: DUR_W, default 10, meaning note duration width in ms.
REQ-004 Parameters: DEPTH, default 64, meaning sequence RAM entries, power of two; AW = log2(DEPTH).
REQ-005 Ports: clk  in  1  system clock; reset  in  1  asynchronous active-high reset.
REQ-006 Ports: start  in  1  begin playback at entry 0; stop  in  1  abort playback.
REQ-007 Ports: loop_en  in  1  restart at entry 0 after last entry; seq_len  in  AW+1  entries to play (1..DEPTH).
REQ-008 Ports: wr_en  in  1; wr_addr  in  AW; wr_data  in  HP_W+DUR_W  {half_period, duration}; loads sequence RAM.
REQ-009 Ports: piezo  out  1  square-wave output; busy  out  1  playback active; note_idx  out  AW  current entry; done  out  1  one-cycle pulse at sequence end.

Function
REQ-010 The block SHALL generate a us tick every DIV_US clk cycles and an ms tick every 1000 us ticks; both dividers SHALL run only while busy and clear on entering LOAD.
REQ-011 The FSM SHALL have states IDLE, LOAD, PLAY, GAP (macro-dependent), DONE.
REQ-012 IDLE -> LOAD on start; LOAD lasts exactly one cycle (synchronous RAM read) then -> PLAY.
REQ-013 In PLAY, piezo SHALL toggle every half_period us ticks, starting low at PLAY entry; half_period = 0 is a rest with piezo held low.
REQ-014 PLAY SHALL last duration ms ticks; duration = 0 SHALL be treated as 1.
REQ-015 At PLAY end: if note_idx = seq_len-1 and loop_en = 0 -> DONE; if loop_en = 1 -> note_idx wraps to 0 -> LOAD; else note_idx+1 -> LOAD.
REQ-016 DONE SHALL last one cycle asserting done, then -> IDLE.
REQ-017 busy SHALL be 1 in LOAD, PLAY, GAP, DONE; 0 in IDLE.
REQ-018 start while busy SHALL be ignored.
REQ-019 stop SHALL force IDLE on the next edge from any state, piezo low, note_idx 0, no done pulse; stop has priority over simultaneous start.
REQ-020 seq_len = 0 or > DEPTH SHALL be treated as DEPTH; seq_len is sampled at start.
REQ-021 RAM writes SHALL be accepted in any state; a write to the entry being played takes effect at its next LOAD.
REQ-022 Counters SHALL saturate-free compare with >=; no counter SHALL exceed its field width.

Reset
REQ-023 While reset = 1: state IDLE, piezo 0, busy 0, done 0, note_idx 0, all counters 0; RAM contents are undefined and not cleared.
REQ-024 Reset asserted mid-playback SHALL silence piezo immediately (asynchronously).

Configuration
REQ-025 Macro MELODY_GAP_EN defined: after each PLAY, state GAP holds piezo low for GAP_MS ms ticks (parameter, default 20) before the REQ-015 decision; GAP_MS = 0 skips GAP.
REQ-026 Macro MELODY_GAP_EN undefined: GAP state and GAP_MS absent; PLAY proceeds directly per REQ-015.

Structure
REQ-027 Package melody_pkg SHALL hold the FSM state enum, the note entry struct {half_period, duration}, and the 1000 us-per-ms constant.
REQ-028 Sub-module tone_gen SHALL contain the half-period counter and piezo toggle flop, driven by the us tick, a clear, and half_period.

Verification (DIV_US = 1)
REQ-029 Load entry0 = {HP 500, DUR 2}, seq_len 1, start -> piezo toggles every 500 cycles, 4 toggles, done pulse 2000 cycles + LOAD after start, busy then 0.
REQ-030 Entry {HP 0, DUR 3} -> piezo stays 0 for 3000 cycles, then done.
REQ-031 3 entries, loop_en 1 -> note_idx sequence 0,1,2,0,1; clear loop_en during entry 2 -> done after entry 2.
REQ-032 stop and start asserted together mid-entry 1 -> IDLE next cycle, piezo 0, note_idx 0, no done.
REQ-033 Reset pulse mid-PLAY -> piezo 0 asynchronously; start after release plays from entry 0.
REQ-034 With MELODY_GAP_EN, GAP_MS 5, two entries DUR 2 -> 5000-cycle silence between and after notes before done.

Source files
------------

// File: rtl/melody_pkg.sv
// melody_pkg: shared FSM states, note entry layout and timing constants for melody_player.
// GAP state exists only when MELODY_GAP_EN is defined.
package melody_pkg;
  localparam int US_PER_MS = 1000;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
`ifdef MELODY_GAP_EN
    GAP,
`endif
    DONE
  } state_t;
  // Fields are wide enough for any HP_W/DUR_W up to 32; entries are zero-extended into them.
  typedef struct packed {
    logic [31:0] half_period;
    logic [31:0] duration;
  } note_t;
endpackage

// File: rtl/tone_gen.sv
// tone_gen: square-wave generator toggling piezo every half_period us ticks; half_period 0 is a rest.
module tone_gen #(
  parameter int HP_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        clear,
  input  logic [31:0] half_period,
  output logic        piezo
);
  logic [HP_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      piezo <= 1'b0;
    end else if (clear || half_period == 0) begin
      cnt <= '0;
      piezo <= 1'b0;
    end else if (tick) begin
      cnt <= 32'(cnt) + 32'd1 >= half_period ? '0 : cnt + 1'b1;
      piezo <= 32'(cnt) + 32'd1 >= half_period ? ~piezo : piezo;
    end
  end
endmodule

// File: rtl/melody_player.sv
// melody_player: plays {half_period, duration} entries from a sequence RAM as a piezo square wave.
// Define MELODY_GAP_EN to insert GAP_MS ms of silence after every note.
module melody_player
  import melody_pkg::*;
#(
  parameter int DIV_US = 50,
  parameter int HP_W = 12,
  parameter int DUR_W = 10,
  parameter int DEPTH = 64
`ifdef MELODY_GAP_EN
  , parameter int GAP_MS = 20
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [$clog2(DEPTH):0]    seq_len,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [HP_W+DUR_W-1:0]     wr_data,
  output logic                      piezo,
  output logic                      busy,
  output logic [$clog2(DEPTH)-1:0]  note_idx,
  output logic                      done
);
  localparam int AW = $clog2(DEPTH);
  localparam int UW = $clog2(DIV_US + 1);
  localparam int MW = $clog2(US_PER_MS);
`ifdef MELODY_GAP_EN
  localparam int GW = $clog2(GAP_MS + 1);
  localparam int CW = DUR_W > GW ? DUR_W : GW;
`else
  localparam int CW = DUR_W;
`endif
  state_t state, nxt, after;
  logic [UW-1:0] us_cnt;
  logic [MW-1:0] ms_cnt;
  logic [CW-1:0] cnt;
  logic [AW:0] len;
  logic [HP_W+DUR_W-1:0] mem [DEPTH];
  logic [HP_W+DUR_W-1:0] rd;
  note_t note;
  logic run, us_tick, ms_tick, play_end, last;
`ifdef MELODY_GAP_EN
  logic gap_end;
`endif
  assign note = '{half_period: 32'(rd[HP_W+DUR_W-1:DUR_W]), duration: 32'(rd[DUR_W-1:0])};
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
`ifdef MELODY_GAP_EN
    run = state == PLAY || state == GAP;
`else
    run = state == PLAY;
`endif
    us_tick = run && us_cnt >= UW'(DIV_US - 1);
    ms_tick = us_tick && ms_cnt >= MW'(US_PER_MS - 1);
    play_end = state == PLAY && ms_tick && 32'(cnt) + 32'd1 >= (note.duration == 0 ? 32'd1 : note.duration);
    last = {1'b0, note_idx} == len - 1'b1;
    after = last && !loop_en ? DONE : LOAD;
`ifdef MELODY_GAP_EN
    gap_end = state == GAP && ms_tick && 32'(cnt) + 32'd1 >= 32'(GAP_MS);
`endif
    nxt = state;
    case (state)
      IDLE: nxt = start ? LOAD : IDLE;
      LOAD: nxt = PLAY;
`ifdef MELODY_GAP_EN
      PLAY: nxt = play_end ? (GAP_MS == 0 ? after : GAP) : PLAY;
      GAP:  nxt = gap_end ? after : GAP;
`else
      PLAY: nxt = play_end ? after : PLAY;
`endif
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (stop) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      us_cnt <= '0;
      ms_cnt <= '0;
      cnt <= '0;
      len <= '0;
      note_idx <= '0;
    end else begin
      state <= nxt;
      us_cnt <= !run || us_tick ? '0 : us_cnt + 1'b1;
      ms_cnt <= !run || ms_tick ? '0 : ms_cnt + MW'(us_tick);
      cnt <= nxt != state ? '0 : cnt + CW'(ms_tick);
      note_idx <= nxt == IDLE || state == IDLE ? '0 : nxt == LOAD ? (last ? '0 : note_idx + 1'b1) : note_idx;
      if (state == IDLE && nxt == LOAD)
        len <= seq_len == 0 || seq_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : seq_len;
    end
  end
  // The read register only updates in LOAD, so a write to the playing entry shows up at its next LOAD.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (state == LOAD) rd <= mem[note_idx];
  end
  tone_gen #(.HP_W(HP_W)) u_tone (
    .clk(clk),
    .reset(reset),
    .tick(us_tick),
    .clear(nxt != PLAY),
    .half_period(note.half_period),
    .piezo(piezo)
  );
endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: checks melody_player cycle by cycle against a note-timeline model built from playback rules.
module tb_melody_player;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int HP_W = 12;
  localparam int DUR_W = 10;
  localparam int DW = HP_W + DUR_W;
`ifdef MELODY_GAP_EN
  localparam int GAP = 5;
`else
  localparam int GAP = 0;
`endif
  localparam int NR = GAP > 0 ? 1 : 2;
  typedef struct {bit p; int idx; bit busy; bit done;} exp_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
  logic [AW:0] seq_len = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic piezo, busy, done;
  logic [AW-1:0] note_idx;
  logic [DW-1:0] mram [DEPTH];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  melody_player #(
    .DIV_US(1), .HP_W(HP_W), .DUR_W(DUR_W), .DEPTH(DEPTH)
`ifdef MELODY_GAP_EN
    , .GAP_MS(GAP)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .piezo(piezo), .busy(busy), .note_idx(note_idx), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int hp, input int dur);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = {HP_W'(hp), DUR_W'(dur)};
    mram[a] = wr_data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Expected timeline: per note one LOAD cycle, dur*1000 PLAY cycles, GAP*1000 silent cycles; DONE after last.
  task automatic play(input string tag, input int len_in, input bit lp, input int loop_off, input int again,
                      input int stop_at, input int wr_at, input int wa, input logic [DW-1:0] wd);
    exp_t q[$];
    exp_t e;
    int eff, t, idx, hp, dur, bp, bi, bb, bd;
    bit wdone;
    logic [DW-1:0] ent;
    eff = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
    t = 0;
    idx = 0;
    wdone = 1'b0;
    forever begin
      if (wr_at >= 0 && !wdone && wr_at < t) begin
        mram[wa] = wd;
        wdone = 1'b1;
      end
      ent = mram[idx];
      hp = int'(ent[DW-1:DUR_W]);
      dur = int'(ent[DUR_W-1:0]);
      if (dur == 0) dur = 1;
      q.push_back('{1'b0, idx, 1'b1, 1'b0});
      t++;
      for (int k = 0; k < dur * 1000; k++) begin
        q.push_back('{hp != 0 && (k / hp) % 2 == 1, idx, 1'b1, 1'b0});
        t++;
      end
      for (int k = 0; k < GAP * 1000; k++) begin
        q.push_back('{1'b0, idx, 1'b1, 1'b0});
        t++;
      end
      if (idx == eff - 1 && !(lp && !(loop_off >= 0 && loop_off <= t - 1))) begin
        q.push_back('{1'b0, idx, 1'b1, 1'b1});
        break;
      end
      idx = idx == eff - 1 ? 0 : idx + 1;
      if ((stop_at >= 0 && t > stop_at) || t > 40000) break;
    end
    if (wr_at >= 0 && !wdone) mram[wa] = wd;
    if (stop_at >= 0) while (q.size() > stop_at + 1) void'(q.pop_back());
    for (int k = 0; k < 3; k++) q.push_back('{1'b0, 0, 1'b0, 1'b0});
    bp = 0; bi = 0; bb = 0; bd = 0;
    @(negedge clk);
    start = 1'b1;
    seq_len = (AW+1)'(len_in);
    loop_en = lp;
    for (int c = 0; c < q.size(); c++) begin
      @(negedge clk);
      e = q[c];
      if (piezo !== e.p) bp++;
      if (note_idx !== AW'(e.idx)) bi++;
      if (busy !== e.busy) bb++;
      if (done !== e.done) bd++;
      start = c == again || c == stop_at;
      stop = c == stop_at;
      if (c == 0) seq_len = (AW+1)'($urandom);
      if (c == loop_off) loop_en = 1'b0;
      wr_en = c == wr_at;
      if (c == wr_at) begin
        wr_addr = AW'(wa);
        wr_data = wd;
      end
    end
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    wr_en = 1'b0;
    check({tag, ".piezo_bad_cycles"}, bp, 0);
    check({tag, ".idx_bad_cycles"}, bi, 0);
    check({tag, ".busy_bad_cycles"}, bb, 0);
    check({tag, ".done_bad_cycles"}, bd, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset.piezo", piezo, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.idx", note_idx, 0);
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) wr(a, 0, 1);
    wr(0, 500, 2);
    play("tone500", 1, 1'b0, -1, 700, -1, -1, 0, '0);
    wr(0, 0, 3);
    play("rest", 1, 1'b0, -1, -1, -1, -1, 0, '0);
    for (int r = 0; r < NR; r++) begin
      for (int a = 0; a < DEPTH; a++)
        wr(a, $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 700), $urandom_range(0, 2));
      play($sformatf("rand%0d", r), $urandom_range(1, 3), 1'b0, -1, -1, -1, -1, 0, '0);
    end
`ifndef MELODY_GAP_EN
    for (int a = 0; a < 3; a++) wr(a, $urandom_range(1, 400), 1);
    play("loop", 3, 1'b1, 5500, -1, -1, 500, 0, {HP_W'(37), DUR_W'(1)});
    for (int a = 0; a < DEPTH; a++) wr(a, $urandom_range(0, 300), 1);
    play("len0", 0, 1'b0, -1, -1, -1, -1, 0, '0);
    play("len7", 7, 1'b0, -1, 2500, -1, -1, 0, '0);
`else
    wr(0, 250, 2);
    wr(1, 0, 2);
    play("gap", 2, 1'b0, -1, -1, -1, -1, 0, '0);
`endif
    for (int a = 0; a < 3; a++) wr(a, $urandom_range(1, 400), 1);
    play("stop", 3, 1'b0, -1, -1, 1501 + GAP * 1000, -1, 0, '0);
    wr(0, 100, 1);
    wr(1, 60, 1);
    @(negedge clk);
    start = 1'b1;
    seq_len = 2;
    @(negedge clk);
    start = 1'b0;
    repeat (151) @(negedge clk);
    check("midplay.piezo_high", piezo, 1);
    #1 reset = 1'b1;
    #1;
    check("async_reset.piezo", piezo, 0);
    check("async_reset.busy", busy, 0);
    check("async_reset.idx", note_idx, 0);
    check("async_reset.done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    play("replay", 2, 1'b0, -1, -1, -1, -1, 0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
